// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the data-RAM arbiter, the CPU top and the RAM instance.
// Pure declarations: no latency, no flow control.
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 7;
  localparam int RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_ACK
  } arb_state_t;

  // Width needed to hold 0..limit; a zero limit still needs one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ram_arb_starve_cnt.sv
// Saturating count of CPU-blocked WAIT cycles; at_limit flags the forced-grant cycle.
// at_limit is combinational from the count register; clr wins over inc.
module ram_arb_starve_cnt
  import ram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_limit = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Muxes the single-port data RAM between the CPU (fixed priority) and a req/ack host port.
// Host ack 2 cycles after req, at most STARVE_LIMIT more; cpu_hold freezes the CPU for the forced grant.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = RAM_ADDR_W,
  parameter int DATA_W       = RAM_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_q
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [DATA_W-1:0] host_rdata_q;
  logic [DATA_W-1:0] host_rdata_d;
  logic              in_wait;
  logic              at_limit;
  logic              host_gnt;
  logic              starve_clr;

  assign in_wait    = (state_q == ARB_WAIT);
  assign host_gnt   = in_wait && (!cpu_req || at_limit);
  // Counting only runs while the host is blocked in WAIT.
  assign starve_clr = !in_wait || host_gnt;

  ram_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (starve_clr),
    .inc      (!starve_clr),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d      = state_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      ARB_IDLE: if (host_req) state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (host_gnt) begin
          state_d = ARB_ACK;
          if (!host_we) host_rdata_d = ram_q;
        end
      end
      ARB_ACK:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Reset gates the strobes so nothing is written and the CPU is never frozen while rst=0.
  assign cpu_hold   = rst && in_wait && cpu_req && at_limit;
  assign ram_addr   = host_gnt ? host_addr : cpu_addr;
  assign ram_data   = host_gnt ? host_wdata : cpu_wdata;
  assign ram_en     = rst && (host_gnt ? host_we : (cpu_req && cpu_we));
  assign cpu_rdata  = ram_q;
  assign host_ack   = (state_q == ARB_ACK);
  assign host_rdata = host_rdata_q;
  assign host_busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with RAM models; host acks are checked against a scoreboard.
// A second instance with STARVE_LIMIT=0 shares the host inputs but has its own cpu_req.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_req0, cpu_we;
  logic [6:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       host_req, host_we;
  logic [6:0] host_addr;
  logic [7:0] host_wdata;

  logic [7:0] cpu_rdata, host_rdata, ram_data, ram_q;
  logic [6:0] ram_addr;
  logic       cpu_hold, host_ack, host_busy, ram_en;
  logic [7:0] cpu_rdata0, host_rdata0, ram_data0, ram_q0;
  logic [6:0] ram_addr0;
  logic       cpu_hold0, host_ack0, host_busy0, ram_en0;

  logic [7:0] mem      [128];
  logic [7:0] mem0     [128];
  logic [7:0] exp_mem  [128];

  typedef struct {
    bit         is_rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  int cyc    = 0;
  int c0     = 0;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter #(.ADDR_W(7), .DATA_W(8), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_busy(host_busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_en(ram_en), .ram_q(ram_q)
  );

  ram_arbiter #(.ADDR_W(7), .DATA_W(8), .STARVE_LIMIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req0), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata0), .cpu_hold(cpu_hold0),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack0), .host_rdata(host_rdata0), .host_busy(host_busy0),
    .ram_addr(ram_addr0), .ram_data(ram_data0), .ram_en(ram_en0), .ram_q(ram_q0)
  );

  always @(posedge clk) if (ram_en) mem[ram_addr] <= ram_data;
  always @(posedge clk) if (ram_en0) mem0[ram_addr0] <= ram_data0;
  assign ram_q  = mem[ram_addr];
  assign ram_q0 = mem0[ram_addr0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input bit is_rd, input logic [7:0] data, input int at_cyc);
    exp_t e;
    e.is_rd = is_rd;
    e.data  = data;
    e.cyc   = at_cyc;
    sb_q.push_back(e);
  endtask

  // Called just after a rising edge; the request is seen in IDLE this cycle.
  task automatic host_start(input logic we, input logic [6:0] a, input logic [7:0] d,
                            input int stall);
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    host_req   = 1'b1;
    c0         = cyc;
    push_exp(!we, we ? d : exp_mem[a], cyc + 2 + stall);
    if (we) exp_mem[a] = d;
  endtask

  task automatic host_finish(output int holds, output int hold_cyc, output int hold_en,
                             output int en_cnt);
    bit acked = 0;
    holds = 0; hold_cyc = -1; hold_en = 0; en_cnt = 0;
    for (int i = 0; i < 40 && !acked; i++) begin
      @(negedge clk);
      if (ram_en) en_cnt++;
      if (cpu_hold) begin
        holds++;
        hold_cyc = cyc;
        if (ram_en) hold_en++;
      end
      if (host_ack) acked = 1;
    end
    chk("ack_seen", 32'(acked), 32'd1);
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  // Scoreboard: every ack must match the oldest pending expectation in cycle and data.
  always @(negedge clk) begin
    exp_t e;
    if (rst && host_ack) begin
      if (sb_q.size() == 0) begin
        chk("ack_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.is_rd) chk("host_rdata", 32'(host_rdata), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int holds, hold_cyc, hold_en, en_cnt;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'h00; mem0[i] = 8'h00; exp_mem[i] = 8'h00;
    end
    rst = 1'b0; cpu_req = 1'b1; cpu_req0 = 1'b1; cpu_we = 1'b1;
    cpu_addr = 7'h05; cpu_wdata = 8'h77;
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'h05; host_wdata = 8'h66;

    // Reset held with every request active.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_host_ack", 32'(host_ack), 32'd0);
      chk("rst_host_busy", 32'(host_busy), 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1; host_req = 1'b0; cpu_req = 1'b0; cpu_req0 = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(host_busy), 32'd0);
    chk("post_rst_rdata", 32'(host_rdata), 32'd0);
    chk("rst_no_write", 32'(mem[7'h05]), 32'd0);
    @(posedge clk); #1;

    // Uncontended write then read.
    host_start(1'b1, 7'h20, 8'hA5, 0);
    host_finish(holds, hold_cyc, hold_en, en_cnt);
    chk("wr_en_cycles", 32'(en_cnt), 32'd1);
    chk("wr_mem", 32'(mem[7'h20]), 32'hA5);
    host_start(1'b0, 7'h20, 8'h00, 0);
    host_finish(holds, hold_cyc, hold_en, en_cnt);
    chk("rd_en_cycles", 32'(en_cnt), 32'd0);
    @(negedge clk);
    chk("rdata_held", 32'(host_rdata), 32'hA5);
    @(posedge clk); #1;

    // CPU priority: CPU writes through three WAIT cycles, host wins once cpu_req drops.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h0D; cpu_wdata = 8'h3C;
    exp_mem[7'h0D] = 8'h3C;
    host_start(1'b0, 7'h0D, 8'h00, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("prio_cpu_en", 32'(ram_en), 32'd1);
      chk("prio_cpu_addr", 32'(ram_addr), 32'h0D);
      chk("prio_no_hold", 32'(cpu_hold), 32'd0);
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    host_finish(holds, hold_cyc, hold_en, en_cnt);
    chk("prio_holds", 32'(holds), 32'd0);
    chk("prio_cpu_mem", 32'(mem[7'h0D]), 32'h3C);

    // Starvation: host forced through in the ninth WAIT cycle.
    host_start(1'b1, 7'h10, 8'h5A, 0);
    host_finish(holds, hold_cyc, hold_en, en_cnt);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h11; cpu_wdata = 8'h99;
    exp_mem[7'h11] = 8'h99;
    host_start(1'b0, 7'h10, 8'h00, 8);
    host_finish(holds, hold_cyc, hold_en, en_cnt);
    chk("starve_holds", 32'(holds), 32'd1);
    chk("starve_hold_cyc", 32'(hold_cyc), 32'(c0 + 9));
    chk("starve_hold_no_wr", 32'(hold_en), 32'd0);
    chk("starve_en_cycles", 32'(en_cnt), 32'd10);
    @(negedge clk);
    chk("starve_hold_after", 32'(cpu_hold), 32'd0);
    @(posedge clk); #1;

    // Reset pulse while a host write waits behind the CPU; held req restarts it.
    cpu_we = 1'b0; cpu_addr = 7'h31;
    host_we = 1'b1; host_addr = 7'h30; host_wdata = 8'hEE; host_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_en", 32'(ram_en), 32'd0);
    chk("mid_rst_ack", 32'(host_ack), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    push_exp(1'b0, 8'hEE, cyc + 2);
    @(negedge clk);
    chk("mid_rst_idle", 32'(host_busy), 32'd0);
    chk("mid_rst_no_wr", 32'(mem[7'h30]), 32'd0);
    host_finish(holds, hold_cyc, hold_en, en_cnt);
    chk("restart_en", 32'(en_cnt), 32'd1);
    chk("restart_mem", 32'(mem[7'h30]), 32'hEE);
    exp_mem[7'h30] = 8'hEE;

    // Clean restart of both instances, then back-to-back reads with req held.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_req0 = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h40; cpu_wdata = 8'h11;
    host_we = 1'b0; host_addr = 7'h20; host_req = 1'b1;
    c0 = cyc;
    push_exp(1'b1, exp_mem[7'h20], c0 + 2);
    push_exp(1'b1, exp_mem[7'h30], c0 + 5);
    push_exp(1'b1, exp_mem[7'h10], c0 + 8);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("b2b_hold0", 32'(cpu_hold0), 32'((i % 3) == 1));
      chk("b2b_ack0", 32'(host_ack0), 32'((i % 3) == 2));
      chk("b2b_en0", 32'(ram_en0), 32'((i % 3) != 1));
      @(posedge clk); #1;
      if (i == 2) host_addr = 7'h30;
      if (i == 5) host_addr = 7'h10;
      if (i == 8) host_req = 1'b0;
    end
    cpu_req0 = 1'b0;
    chk("lim0_cpu_mem", 32'(mem0[7'h40]), 32'h11);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
